dmem_store_buffer: RTL and testbench
====================================

Name: dmem_store_buffer

Overview:
- Sits between the CPU load/store unit and the data-memory port of mem_system; drives that port's request side.
- Queues committed stores in an in-order FIFO and drains them to memory in order.
- Passes loads through with priority, and forwards data from buffered stores when the youngest matching store fully covers the load.
- Stalls loads on partial overlap.

Parameters:
- DEPTH, 4: store entries (power of 2, >=2).
- LDTAG_W, 4: load tag width; matches the memory system's load tag.
- MAX_LD_STREAK, 8: consecutive load grants allowed while stores are pending before one store is forced.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- st_valid  in  1  committed store offered
- st_ready  out  1  store accepted when st_valid and st_ready are both 1
- st_addr  in  32  byte address; word index is addr[31:2]
- st_wdata  in  32  store data, lane-aligned
- st_wmask  in  4  byte enables
- ld_valid  in  1  load offered
- ld_ready  out  1  load accepted when ld_valid and ld_ready are both 1
- ld_addr  in  32  load address
- ld_mask  in  4  bytes needed
- ld_tag  in  LDTAG_W  load tag
- fwd_valid  out  1  forwarded load response
- fwd_tag  out  LDTAG_W  tag of forwarded load
- fwd_data  out  32  forwarded data; bytes outside ld_mask are 0
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts
- mem_req_we  out  1  1 = store, 0 = load
- mem_req_addr  out  32  request address
- mem_req_wdata  out  32  store data
- mem_req_wmask  out  4  store byte enables (load: ld_mask)
- mem_req_tag  out  LDTAG_W  load tag (store: 0)
- sb_empty  out  1  no stores buffered (used for fence/drain)
- sb_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset, synchronous on rst=1:
  - Clear all entries, pointers, count and streak counter.
  - Drive fwd_valid=0, sb_empty=1, sb_count=0.
  - Force mem_req_valid, st_ready and ld_ready to 0 while rst=1.
  - Stores buffered at reset are discarded, including a mid-drain store not yet accepted.
- Store enqueue:
  - st_ready = !full. No same-cycle enqueue into a full buffer, even if a dequeue happens that cycle.
  - An accepted entry is visible to arbitration and matching from the next cycle.
- Load/store matching is per word, on addr[31:2] equality, and considers valid buffered entries only.
- Load classification:
  - NOHIT: no match.
  - FWD: the youngest match has (entry.wmask & ld_mask) == ld_mask.
  - PARTIAL: otherwise.
  - Same-cycle hazard: if st_valid && st_ready and the offered store matches the load's word, treat the load as PARTIAL.
- FWD load:
  - ld_ready=1 with no memory request.
  - Next cycle: fwd_valid=1 for exactly 1 cycle, fwd_tag=ld_tag, fwd_data=entry.wdata masked by ld_mask.
- PARTIAL load: ld_ready=0 until the blocking entries drain.
- Arbitration for mem_req, evaluated each cycle. The candidate store is the head entry; the candidate load is a NOHIT ld_valid.
  - Force the store if the buffer is full, or if streak == MAX_LD_STREAK with stores pending.
  - Otherwise the load wins if it is present; else the store if not empty; else mem_req_valid=0.
  - ld_ready for a NOHIT load = load selected && mem_req_ready (combinational).
  - Head store dequeues on mem_req_valid && mem_req_ready && mem_req_we.
- Request stability: once mem_req_valid=1 is presented and not accepted, the same request is held stable. Arbitration re-evaluates only after acceptance.
  - Exception: a load request may be withdrawn if ld_valid drops; the LSU never does this.
- Streak counter:
  - Increments on each accepted load while !empty.
  - Clears on store accept or when empty.
  - Saturates at MAX_LD_STREAK.
- Ordering and status:
  - Stores leave strictly in FIFO order. Memory completes requests in issue order, so no tracking is needed after acceptance.
  - sb_empty/sb_count are registered and reflect the post-edge state.
  - Simultaneous enqueue and dequeue leaves count unchanged; pointers wrap modulo DEPTH.

Decomposition:
- Package sb_pkg:
  - sb_entry_t {valid, addr[31:2], wdata, wmask}.
  - Load class enum {NOHIT, FWD, PARTIAL}.
  - WORD_OFS=2.
- Sub-module sb_match (combinational):
  - Inputs: entries, head pointer, load word/mask.
  - Outputs: load class, youngest-match index, masked forward data.
  - Uses an age-ordered priority search from tail-1 back to head.

Test Plan:
1. Store 0x100/0xDEADBEEF/mask F at cycle t, mem_req_ready=1, no loads -> mem_req_valid/we=1 at t+1 with addr 0x100, data 0xDEADBEEF; sb_empty=1 from t+2.
2. Stores 0x200/0x11111111 then 0x200/0x22222222 with mem_req_ready=0; load 0x200 mask F tag 3 -> ld_ready=1, fwd_valid next cycle with tag 3, data 0x22222222; no load request issued.
3. Store 0x300 mask 1 with mem_req_ready=0; load 0x300 mask F -> ld_ready=0. Raise ready -> store issues first, then the load goes to memory with we=0, tag preserved.
4. DEPTH=4 stores to distinct words with ready=0 -> st_ready=0, sb_count=4. Pending non-matching load plus ready=1 -> first grant is the head store.
5. MAX_LD_STREAK=4, one store pending, continuous non-matching loads, ready=1 -> store granted on the 5th grant, then loads resume.
6. Three entries buffered, rst=1 for one cycle mid-drain -> next cycle sb_count=0, sb_empty=1, mem_req_valid=0; the discarded stores are never issued.

Source files
------------

// File: rtl/dmem_store_buffer_pkg.sv
// Shared types for the data-memory store buffer: entry layout, load
// classification and the byte-lane mask expansion helper.
package sb_pkg;

  localparam int WORD_OFS = 2;

  typedef struct packed {
    logic                valid;
    logic [31:WORD_OFS]  addr;
    logic [31:0]         wdata;
    logic [3:0]          wmask;
  } sb_entry_t;

  typedef enum logic [1:0] {
    NOHIT   = 2'd0,
    FWD     = 2'd1,
    PARTIAL = 2'd2
  } ld_class_t;

  // Expand a 4-bit byte-enable into a 32-bit lane mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      r[b*8 +: 8] = {8{m[b]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_store_buffer_if.sv
// LSU / memory-port bundle around the store buffer. The buffer uses the
// slave view; the surrounding environment (LSU, memory, bench) uses master.
interface dmem_store_buffer_if #(
  parameter int LDTAG_W = 4,
  parameter int CNT_W   = 3
);

  logic               st_valid;
  logic               st_ready;
  logic [31:0]        st_addr;
  logic [31:0]        st_wdata;
  logic [3:0]         st_wmask;

  logic               ld_valid;
  logic               ld_ready;
  logic [31:0]        ld_addr;
  logic [3:0]         ld_mask;
  logic [LDTAG_W-1:0] ld_tag;

  logic               fwd_valid;
  logic [LDTAG_W-1:0] fwd_tag;
  logic [31:0]        fwd_data;

  logic               mem_req_valid;
  logic               mem_req_ready;
  logic               mem_req_we;
  logic [31:0]        mem_req_addr;
  logic [31:0]        mem_req_wdata;
  logic [3:0]         mem_req_wmask;
  logic [LDTAG_W-1:0] mem_req_tag;

  logic               sb_empty;
  logic [CNT_W-1:0]   sb_count;

  modport slave (
    input  st_valid, st_addr, st_wdata, st_wmask,
    output st_ready,
    input  ld_valid, ld_addr, ld_mask, ld_tag,
    output ld_ready,
    output fwd_valid, fwd_tag, fwd_data,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_wmask, mem_req_tag,
    input  mem_req_ready,
    output sb_empty, sb_count
  );

  modport master (
    output st_valid, st_addr, st_wdata, st_wmask,
    input  st_ready,
    output ld_valid, ld_addr, ld_mask, ld_tag,
    input  ld_ready,
    input  fwd_valid, fwd_tag, fwd_data,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_wmask, mem_req_tag,
    output mem_req_ready,
    input  sb_empty, sb_count
  );

endinterface

// File: rtl/dmem_store_buffer_match.sv
// Load-vs-buffer matcher: finds the youngest valid entry on the load's word
// and classifies the load as no-hit, fully forwardable, or partial.
module sb_match
  import sb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  sb_entry_t          ent [DEPTH],
  input  logic [PW-1:0]      head,
  input  logic [31:WORD_OFS] ld_word,
  input  logic [3:0]         ld_mask,
  output ld_class_t          ld_class,
  output logic [PW-1:0]      hit_idx,
  output logic [31:0]        fwd_data
);

  logic          hit;
  logic [PW-1:0] idx;

  // Walk from youngest (tail-1) back to head; first valid word match wins.
  // Valid entries are contiguous from head, so age k maps to head+k.
  always_comb begin
    hit     = 1'b0;
    hit_idx = head;
    idx     = head;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = head + PW'(k);
      if (!hit && ent[idx].valid && (ent[idx].addr == ld_word)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  // Forwarding is only legal when the youngest match covers every needed byte.
  always_comb begin
    ld_class = NOHIT;
    fwd_data = ent[hit_idx].wdata & byte_mask(ld_mask);
    if (hit) begin
      if ((ent[hit_idx].wmask & ld_mask) == ld_mask) ld_class = FWD;
      else                                            ld_class = PARTIAL;
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// In-order store buffer in front of the data-memory request port. Stores are
// queued and drained FIFO; loads bypass with priority, forward from fully
// covering buffered stores, and stall on partial overlap. A streak limit keeps
// a steady load stream from starving pending stores.
module dmem_store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int LDTAG_W       = 4,
  parameter int MAX_LD_STREAK = 8
) (
  input logic               clk,
  input logic               rst,
  dmem_store_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(MAX_LD_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LD_STREAK);

  sb_entry_t          ent_q [DEPTH];
  sb_entry_t          ent_d [DEPTH];
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic [SW-1:0]      streak_q, streak_d;
  logic               lock_q, lock_d;
  logic               lock_we_q, lock_we_d;
  logic               fwd_valid_q, fwd_valid_d;
  logic [LDTAG_W-1:0] fwd_tag_q, fwd_tag_d;
  logic [31:0]        fwd_data_q, fwd_data_d;

  ld_class_t          match_class;
  ld_class_t          ld_class;
  logic [31:0]        match_fwd_data;
  // Youngest-match index is exposed by the matcher for debug probing only.
  logic [PW-1:0]      unused_match_idx;
  logic               unused_st_ofs;

  logic               empty, full, force_st, hazard;
  logic               st_ready_int, ld_ready_int;
  logic               sel_st, sel_ld;
  logic               enq, deq, ld_acc;

  assign unused_st_ofs = ^bus.st_addr[WORD_OFS-1:0];

  sb_match #(.DEPTH(DEPTH)) u_match (
    .ent      (ent_q),
    .head     (head_q),
    .ld_word  (bus.ld_addr[31:WORD_OFS]),
    .ld_mask  (bus.ld_mask),
    .ld_class (match_class),
    .hit_idx  (unused_match_idx),
    .fwd_data (match_fwd_data)
  );

  // Classification, arbitration and the memory request mux.
  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == CW'(DEPTH));
    st_ready_int = !full && !rst;
    // A store entering this very cycle is invisible to the matcher but may
    // be older than the load in program order, so the load must wait.
    hazard       = bus.st_valid && st_ready_int &&
                   (bus.st_addr[31:WORD_OFS] == bus.ld_addr[31:WORD_OFS]);
    ld_class     = hazard ? PARTIAL : match_class;
    force_st     = full || ((streak_q == STREAK_MAX) && !empty);

    sel_st = 1'b0;
    sel_ld = 1'b0;
    if (lock_q && lock_we_q) begin
      sel_st = 1'b1;
    end else if (lock_q && !lock_we_q && bus.ld_valid) begin
      sel_ld = 1'b1;
    end else if (force_st) begin
      sel_st = 1'b1;
    end else if (bus.ld_valid && (ld_class == NOHIT)) begin
      sel_ld = 1'b1;
    end else if (!empty) begin
      sel_st = 1'b1;
    end
    if (rst) begin
      sel_st = 1'b0;
      sel_ld = 1'b0;
    end

    bus.mem_req_valid = sel_st || sel_ld;
    bus.mem_req_we    = sel_st;
    bus.mem_req_addr  = '0;
    bus.mem_req_wdata = '0;
    bus.mem_req_wmask = '0;
    bus.mem_req_tag   = '0;
    if (sel_st) begin
      bus.mem_req_addr  = {ent_q[head_q].addr, {WORD_OFS{1'b0}}};
      bus.mem_req_wdata = ent_q[head_q].wdata;
      bus.mem_req_wmask = ent_q[head_q].wmask;
    end else if (sel_ld) begin
      bus.mem_req_addr  = bus.ld_addr;
      bus.mem_req_wmask = bus.ld_mask;
      bus.mem_req_tag   = bus.ld_tag;
    end

    ld_ready_int = 1'b0;
    if (sel_ld) begin
      ld_ready_int = bus.mem_req_ready;
    end else if (!rst && bus.ld_valid && (ld_class == FWD)) begin
      ld_ready_int = 1'b1;
    end
    bus.ld_ready = ld_ready_int;
    bus.st_ready = st_ready_int;
  end

  // Next-state for entries, pointers, streak, request lock and forward reply.
  always_comb begin
    enq    = bus.st_valid && st_ready_int;
    deq    = sel_st && bus.mem_req_ready;
    ld_acc = bus.ld_valid && ld_ready_int;

    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    if (deq) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + PW'(1);
    end
    if (enq) begin
      ent_d[tail_q] = '{valid: 1'b1,
                        addr:  bus.st_addr[31:WORD_OFS],
                        wdata: bus.st_wdata,
                        wmask: bus.st_wmask};
      tail_d        = tail_q + PW'(1);
    end

    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    streak_d = streak_q;
    if (deq || empty) begin
      streak_d = '0;
    end else if (ld_acc && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + SW'(1);
    end

    // Remember an unaccepted request so next cycle presents it unchanged.
    lock_d    = bus.mem_req_valid && !bus.mem_req_ready;
    lock_we_d = bus.mem_req_we;

    fwd_valid_d = ld_acc && !sel_ld;
    fwd_tag_d   = bus.ld_tag;
    fwd_data_d  = match_fwd_data;
  end

  // State registers with synchronous reset; buffered stores are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      streak_q    <= '0;
      lock_q      <= 1'b0;
      lock_we_q   <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_tag_q   <= '0;
      fwd_data_q  <= '0;
    end else begin
      ent_q       <= ent_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      streak_q    <= streak_d;
      lock_q      <= lock_d;
      lock_we_q   <= lock_we_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_tag_q   <= fwd_tag_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign bus.fwd_valid = fwd_valid_q;
  assign bus.fwd_tag   = fwd_tag_q;
  assign bus.fwd_data  = fwd_data_q;
  assign bus.sb_empty  = (count_q == '0);
  assign bus.sb_count  = count_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed scenarios followed by a randomized phase checked against a
// queue-based model of the store buffer's observable rules.
module tb_dmem_store_buffer;

  localparam int DEPTH   = 4;
  localparam int LDTAG_W = 4;
  localparam int MAXS    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_store_buffer_if #(.LDTAG_W(LDTAG_W), .CNT_W(3)) bus ();

  dmem_store_buffer #(.DEPTH(DEPTH), .LDTAG_W(LDTAG_W), .MAX_LD_STREAK(MAXS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nerr = 0;
  int nchk = 0;

  typedef struct {
    logic [29:0] w;
    logic [31:0] d;
    logic [3:0]  m;
  } mst_t;
  mst_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] m);
    logic [31:0] r;
    r = 32'h0;
    if (m[0]) r = r | 32'h0000_00FF;
    if (m[1]) r = r | 32'h0000_FF00;
    if (m[2]) r = r | 32'h00FF_0000;
    if (m[3]) r = r | 32'hFF00_0000;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic drive_st(input logic v, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m);
    bus.st_valid = v;
    bus.st_addr  = a;
    bus.st_wdata = d;
    bus.st_wmask = m;
  endtask

  task automatic drive_ld(input logic v, input logic [31:0] a, input logic [3:0] m,
                          input logic [3:0] t);
    bus.ld_valid = v;
    bus.ld_addr  = a;
    bus.ld_mask  = m;
    bus.ld_tag   = t;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        st_pend, ld_pend, pstall, pwe;
    logic [31:0] paddr, pdata;
    int          streak_m;
    logic        fexp;
    logic [3:0]  ftag;
    logic [31:0] fdata;
    int          n;
    logic        hit, hazard, is_fwd, is_part, held_ld, held_st;
    logic        ld_acc, st_acc, deq;
    logic [3:0]  mm;
    logic [31:0] md;

    rst = 1'b1;
    drive_st(1'b0, 32'h0, 32'h0, 4'h0);
    drive_ld(1'b0, 32'h0, 4'h0, 4'h0);
    bus.mem_req_ready = 1'b0;

    // Reset behaviour
    tick();
    settle();
    chk1("rst_st_ready", bus.st_ready, 1'b0);
    chk1("rst_ld_ready", bus.ld_ready, 1'b0);
    chk1("rst_mem_valid", bus.mem_req_valid, 1'b0);
    tick();
    rst = 1'b0;
    settle();
    chk1("rst_sb_empty", bus.sb_empty, 1'b1);
    chk("rst_sb_count", 32'(bus.sb_count), 32'd0);
    chk1("rst_fwd_valid", bus.fwd_valid, 1'b0);
    chk1("rst_st_ready_after", bus.st_ready, 1'b1);

    // 1: single store drains the cycle after it is accepted
    tick();
    bus.mem_req_ready = 1'b1;
    drive_st(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    settle();
    chk1("t1_accept", bus.st_ready, 1'b1);
    chk1("t1_no_req_yet", bus.mem_req_valid, 1'b0);
    tick();
    drive_st(1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    chk1("t1_req_valid", bus.mem_req_valid, 1'b1);
    chk1("t1_req_we", bus.mem_req_we, 1'b1);
    chk("t1_req_addr", bus.mem_req_addr, 32'h100);
    chk("t1_req_wdata", bus.mem_req_wdata, 32'hDEAD_BEEF);
    chk("t1_req_wmask", 32'(bus.mem_req_wmask), 32'hF);
    chk("t1_req_tag", 32'(bus.mem_req_tag), 32'h0);
    tick();
    settle();
    chk1("t1_empty", bus.sb_empty, 1'b1);
    chk1("t1_idle", bus.mem_req_valid, 1'b0);

    // 2: forwarding from the youngest of two stores to the same word
    tick();
    bus.mem_req_ready = 1'b0;
    drive_st(1'b1, 32'h200, 32'h1111_1111, 4'hF);
    tick();
    drive_st(1'b1, 32'h200, 32'h2222_2222, 4'hF);
    tick();
    drive_st(1'b0, 32'h0, 32'h0, 4'h0);
    drive_ld(1'b1, 32'h200, 4'hF, 4'd3);
    settle();
    chk("t2_count", 32'(bus.sb_count), 32'd2);
    chk1("t2_ld_ready", bus.ld_ready, 1'b1);
    chk1("t2_no_ld_req", bus.mem_req_valid && !bus.mem_req_we, 1'b0);
    tick();
    drive_ld(1'b0, 32'h0, 4'h0, 4'h0);
    settle();
    chk1("t2_fwd_valid", bus.fwd_valid, 1'b1);
    chk("t2_fwd_tag", 32'(bus.fwd_tag), 32'd3);
    chk("t2_fwd_data", bus.fwd_data, 32'h2222_2222);
    tick();
    settle();
    chk1("t2_fwd_pulse", bus.fwd_valid, 1'b0);
    bus.mem_req_ready = 1'b1;
    tick();
    tick();
    settle();
    chk1("t2_drained", bus.sb_empty, 1'b1);

    // 3: partial overlap stalls the load until the store drains
    tick();
    bus.mem_req_ready = 1'b0;
    drive_st(1'b1, 32'h300, 32'h0000_00AA, 4'h1);
    tick();
    drive_st(1'b0, 32'h0, 32'h0, 4'h0);
    drive_ld(1'b1, 32'h300, 4'hF, 4'd5);
    settle();
    chk1("t3_partial_stall", bus.ld_ready, 1'b0);
    chk1("t3_store_pres", bus.mem_req_we, 1'b1);
    tick();
    bus.mem_req_ready = 1'b1;
    settle();
    chk1("t3_still_stalled", bus.ld_ready, 1'b0);
    chk1("t3_store_first", bus.mem_req_we, 1'b1);
    chk("t3_store_addr", bus.mem_req_addr, 32'h300);
    tick();
    settle();
    chk1("t3_ld_req_valid", bus.mem_req_valid, 1'b1);
    chk1("t3_ld_req_we", bus.mem_req_we, 1'b0);
    chk("t3_ld_req_addr", bus.mem_req_addr, 32'h300);
    chk("t3_ld_req_tag", 32'(bus.mem_req_tag), 32'd5);
    chk("t3_ld_req_mask", 32'(bus.mem_req_wmask), 32'hF);
    chk1("t3_ld_ready", bus.ld_ready, 1'b1);
    tick();
    drive_ld(1'b0, 32'h0, 4'h0, 4'h0);

    // 4: full buffer refuses stores and forces the head store out first
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_st(1'b1, 32'h400 + 32'(4 * i), 32'h4000_0000 + 32'(i), 4'hF);
      tick();
    end
    drive_st(1'b0, 32'h0, 32'h0, 4'h0);
    drive_ld(1'b1, 32'h500, 4'hF, 4'd7);
    bus.mem_req_ready = 1'b1;
    settle();
    chk1("t4_full_st_ready", bus.st_ready, 1'b0);
    chk("t4_count", 32'(bus.sb_count), 32'd4);
    chk1("t4_head_first_we", bus.mem_req_we, 1'b1);
    chk("t4_head_first_addr", bus.mem_req_addr, 32'h400);
    chk1("t4_ld_wait", bus.ld_ready, 1'b0);
    tick();
    settle();
    chk("t4_count_after", 32'(bus.sb_count), 32'd3);
    chk1("t4_ld_wins", bus.mem_req_we, 1'b0);
    chk1("t4_ld_ready", bus.ld_ready, 1'b1);
    tick();
    drive_ld(1'b0, 32'h0, 4'h0, 4'h0);
    repeat (3) tick();
    settle();
    chk1("t4_drained", bus.sb_empty, 1'b1);

    // 5: streak limit forces the pending store on the fifth grant
    tick();
    drive_st(1'b1, 32'h600, 32'h6666_6666, 4'hF);
    drive_ld(1'b1, 32'h700, 4'hF, 4'd0);
    settle();
    chk1("t5_first_ld", bus.ld_ready, 1'b1);
    tick();
    drive_st(1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < MAXS; i++) begin
      bus.ld_tag = 4'(i + 1);
      settle();
      chk1("t5_ld_grant", bus.mem_req_valid && !bus.mem_req_we && bus.ld_ready, 1'b1);
      chk("t5_pending", 32'(bus.sb_count), 32'd1);
      tick();
    end
    settle();
    chk1("t5_forced_we", bus.mem_req_we && bus.mem_req_valid, 1'b1);
    chk("t5_forced_addr", bus.mem_req_addr, 32'h600);
    chk("t5_forced_data", bus.mem_req_wdata, 32'h6666_6666);
    chk1("t5_ld_held_off", bus.ld_ready, 1'b0);
    tick();
    settle();
    chk1("t5_ld_resumes", bus.mem_req_valid && !bus.mem_req_we && bus.ld_ready, 1'b1);
    chk1("t5_empty", bus.sb_empty, 1'b1);
    tick();
    drive_ld(1'b0, 32'h0, 4'h0, 4'h0);

    // 6: reset mid-drain discards buffered stores
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_st(1'b1, 32'h800 + 32'(4 * i), 32'h8000_0000 + 32'(i), 4'hF);
      tick();
    end
    drive_st(1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    chk("t6_count", 32'(bus.sb_count), 32'd3);
    chk1("t6_draining", bus.mem_req_valid, 1'b1);
    tick();
    rst = 1'b1;
    bus.mem_req_ready = 1'b1;
    settle();
    chk1("t6_rst_no_req", bus.mem_req_valid, 1'b0);
    chk1("t6_rst_st_ready", bus.st_ready, 1'b0);
    tick();
    rst = 1'b0;
    settle();
    chk("t6_count_cleared", 32'(bus.sb_count), 32'd0);
    chk1("t6_empty", bus.sb_empty, 1'b1);
    chk1("t6_no_req", bus.mem_req_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      settle();
      chk1("t6_never_issued", bus.mem_req_valid, 1'b0);
    end
    tick();

    // Randomized phase against a queue model
    st_pend  = 1'b0;
    ld_pend  = 1'b0;
    pstall   = 1'b0;
    pwe      = 1'b0;
    paddr    = 32'h0;
    pdata    = 32'h0;
    streak_m = 0;
    fexp     = 1'b0;
    ftag     = 4'h0;
    fdata    = 32'h0;
    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.mem_req_ready = ($urandom_range(0, 3) != 0);
      if (!st_pend) begin
        drive_st(1'($urandom_range(0, 1)), 32'h900 + 32'(4 * $urandom_range(0, 3)),
                 $urandom, 4'($urandom_range(1, 15)));
      end
      if (!ld_pend) begin
        drive_ld($urandom_range(0, 2) == 0,
                 ($urandom_range(0, 4) == 4) ? 32'hA00 : 32'h900 + 32'(4 * $urandom_range(0, 3)),
                 4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)));
      end
      settle();

      n = q.size();
      chk("rnd_count", 32'(bus.sb_count), 32'(n));
      chk1("rnd_empty", bus.sb_empty, n == 0);
      chk1("rnd_st_ready", bus.st_ready, n < DEPTH);
      chk1("rnd_fwd_valid", bus.fwd_valid, fexp);
      if (fexp) begin
        chk("rnd_fwd_tag", 32'(bus.fwd_tag), 32'(ftag));
        chk("rnd_fwd_data", bus.fwd_data, fdata);
      end

      held_st = pstall && pwe;
      held_ld = pstall && !pwe && bus.ld_valid;
      if (held_st) begin
        chk1("rnd_hold_st", bus.mem_req_valid && bus.mem_req_we, 1'b1);
        chk("rnd_hold_st_addr", bus.mem_req_addr, paddr);
        chk("rnd_hold_st_data", bus.mem_req_wdata, pdata);
      end

      hit = 1'b0;
      mm  = 4'h0;
      md  = 32'h0;
      for (int k = n - 1; k >= 0; k--) begin
        if (!hit && q[k].w == bus.ld_addr[31:2]) begin
          hit = 1'b1;
          mm  = q[k].m;
          md  = q[k].d;
        end
      end
      hazard  = bus.st_valid && (n < DEPTH) && (bus.st_addr[31:2] == bus.ld_addr[31:2]);
      is_fwd  = hit && !hazard && ((mm & bus.ld_mask) == bus.ld_mask);
      is_part = hazard || (hit && !is_fwd);

      if (bus.ld_valid) begin
        if (held_ld) begin
          chk1("rnd_hold_ld", bus.mem_req_valid && !bus.mem_req_we, 1'b1);
          chk1("rnd_hold_ld_ready", bus.ld_ready, bus.mem_req_ready);
        end else if (is_part) begin
          chk1("rnd_ld_partial", bus.ld_ready, 1'b0);
          chk1("rnd_partial_no_req", bus.mem_req_valid && !bus.mem_req_we, 1'b0);
        end else if (is_fwd) begin
          chk1("rnd_ld_fwd", bus.ld_ready, 1'b1);
          chk1("rnd_fwd_no_req", bus.mem_req_valid && !bus.mem_req_we, 1'b0);
        end else begin
          chk1("rnd_ld_nohit", bus.ld_ready,
               bus.mem_req_valid && !bus.mem_req_we && bus.mem_req_ready);
        end
      end

      if (bus.mem_req_valid && !bus.mem_req_we) begin
        chk1("rnd_ldreq_has_ld", bus.ld_valid, 1'b1);
        chk("rnd_ldreq_addr", bus.mem_req_addr, bus.ld_addr);
        chk("rnd_ldreq_mask", 32'(bus.mem_req_wmask), 32'(bus.ld_mask));
        chk("rnd_ldreq_tag", 32'(bus.mem_req_tag), 32'(bus.ld_tag));
      end
      if (bus.mem_req_valid && bus.mem_req_we) begin
        chk1("rnd_streq_nonempty", n != 0, 1'b1);
        if (n != 0) begin
          chk("rnd_streq_addr", bus.mem_req_addr, {q[0].w, 2'b00});
          chk("rnd_streq_data", bus.mem_req_wdata, q[0].d);
          chk("rnd_streq_mask", 32'(bus.mem_req_wmask), 32'(q[0].m));
          chk("rnd_streq_tag", 32'(bus.mem_req_tag), 32'h0);
        end
      end
      if (!pstall && n > 0 && (n == DEPTH || streak_m == MAXS)) begin
        chk1("rnd_forced_store", bus.mem_req_valid && bus.mem_req_we, 1'b1);
      end
      if (n > 0) chk1("rnd_req_pending", bus.mem_req_valid, 1'b1);

      ld_acc = bus.ld_valid && bus.ld_ready;
      st_acc = bus.st_valid && bus.st_ready;
      deq    = bus.mem_req_valid && bus.mem_req_ready && bus.mem_req_we;
      fexp   = ld_acc && !held_ld && is_fwd;
      ftag   = bus.ld_tag;
      fdata  = md & lanes(bus.ld_mask);
      if (deq || n == 0) streak_m = 0;
      else if (ld_acc && streak_m < MAXS) streak_m++;
      if (deq && n > 0) void'(q.pop_front());
      if (st_acc) q.push_back('{w: bus.st_addr[31:2], d: bus.st_wdata, m: bus.st_wmask});
      pstall  = bus.mem_req_valid && !bus.mem_req_ready;
      pwe     = bus.mem_req_we;
      paddr   = bus.mem_req_addr;
      pdata   = bus.mem_req_wdata;
      st_pend = bus.st_valid && !bus.st_ready;
      ld_pend = bus.ld_valid && !bus.ld_ready;
      tick();
    end

    drive_st(1'b0, 32'h0, 32'h0, 4'h0);
    drive_ld(1'b0, 32'h0, 4'h0, 4'h0);
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 20 && !bus.sb_empty; i++) tick();
    settle();
    chk1("final_drain", bus.sb_empty, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
